// File: rtl/echo_pkg.sv
// Shared types and helpers for the MIDI echo delay line.
// Optional feedback repeats are enabled with `define ECHO_FEEDBACK_EN.
package echo_pkg;

  localparam int DECAY_W = 2;
  localparam int NOTE_W  = 7;
  localparam int VEL_W   = 7;

  // Reference event layout at the default widths (PB_W=9, CC_W=2, TS_W=24).
  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
    logic [8:0]        pb;
    logic [1:0]        cc1;
    logic [1:0]        rpt;
    logic [23:0]       due;
  } echo_evt_t;

  // Gate-on echoes are attenuated but never reach 0, which would read as a note-off.
  function automatic logic [VEL_W-1:0] atten_vel(input logic [VEL_W-1:0] vel,
                                                 input logic [DECAY_W-1:0] decay,
                                                 input logic on);
    logic [VEL_W-1:0] shifted;
    shifted = vel >> ({1'b0, decay} + 3'd1);
    if (!on) begin
      return vel;
    end else if (shifted == 7'd0) begin
      return 7'd1;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/echo_event_fifo.sv
// Synchronous FIFO of packed echo events; a pop frees the slot for a push
// in the same cycle, so a full FIFO still accepts push+pop.
module echo_event_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/echo_delay_line.sv
// Timestamped MIDI echo: captures field changes, replays them delay_ticks later
// with attenuated velocity. `define ECHO_FEEDBACK_EN adds decaying repeats.
module echo_delay_line
  import echo_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int TS_W     = 24,
  parameter int TICK_DIV = 1,
  parameter int PB_W     = 9,
  parameter int CC_W     = 2
`ifdef ECHO_FEEDBACK_EN
  , parameter int MAX_REPEATS = 3
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     note_on,
  input  logic                     note_repeat,
  input  logic [NOTE_W-1:0]        note_start,
  input  logic [VEL_W-1:0]         vel_start,
  input  logic [PB_W-1:0]          pb_start,
  input  logic [CC_W-1:0]          cc1_start,
  input  logic [TS_W-1:0]          delay_ticks,
  input  logic [DECAY_W-1:0]       decay,
  output logic                     echo_valid,
  output logic                     echo_on,
  output logic [NOTE_W-1:0]        echo_note,
  output logic [VEL_W-1:0]         echo_vel,
  output logic [PB_W-1:0]          echo_pb,
  output logic [CC_W-1:0]          echo_cc1,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ECHO_FEEDBACK_EN
  localparam int RPT_W = $clog2(MAX_REPEATS + 1);
`endif

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
    logic [PB_W-1:0]   pb;
    logic [CC_W-1:0]   cc1;
  } fields_t;

  typedef struct packed {
    fields_t           f;
`ifdef ECHO_FEEDBACK_EN
    logic [RPT_W-1:0]  rpt;
`endif
    logic [TS_W-1:0]   due;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  logic             tick_s;
  logic [TS_W-1:0]  now_r;
  fields_t          cur_s;
  fields_t          shadow_r;
  logic             change_s;
  evt_t             cap_evt_s;
  evt_t             wr_evt_s;
  evt_t             head_s;
  logic [EVT_W-1:0] rd_data_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             space_s;
  logic             drop_s;
  logic [CNT_W-1:0] count_s;
  logic [TS_W-1:0]  late_s;
  logic             rel_v_r;
  fields_t          rel_r;
  logic [VEL_W-1:0] rel_vel_s;

  generate
    if (TICK_DIV > 1) begin : g_presc
      localparam int PRE_W = $clog2(TICK_DIV);
      logic [PRE_W-1:0] presc_r;
      // Clock-cycle prescaler producing one delay tick every TICK_DIV cycles.
      always_ff @(posedge clk) begin
        if (reset) begin
          presc_r <= '0;
        end else if (en) begin
          if (presc_r == PRE_W'(TICK_DIV - 1)) begin
            presc_r <= '0;
          end else begin
            presc_r <= presc_r + PRE_W'(1);
          end
        end
      end
      assign tick_s = en && (presc_r == PRE_W'(TICK_DIV - 1));
    end else begin : g_no_presc
      assign tick_s = en;
    end
  endgenerate

  // Free-running timestamp; wraps naturally, due comparison is modular.
  always_ff @(posedge clk) begin
    if (reset) begin
      now_r <= '0;
    end else if (tick_s) begin
      now_r <= now_r + TS_W'(1);
    end
  end

  // Change detection against the shadow copy and the capture entry.
  always_comb begin
    cur_s.on   = note_on;
    cur_s.note = note_start;
    cur_s.vel  = vel_start;
    cur_s.pb   = pb_start;
    cur_s.cc1  = cc1_start;
    change_s   = en && ((cur_s != shadow_r) || note_repeat);
    cap_evt_s.f   = cur_s;
`ifdef ECHO_FEEDBACK_EN
    cap_evt_s.rpt = '0;
`endif
    cap_evt_s.due = now_r + delay_ticks;
  end

  // Shadow of the last sampled fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r <= '0;
    end else if (en) begin
      shadow_r <= cur_s;
    end
  end

  // Head is due once now has reached due, judged by the sign of the modular difference.
  assign head_s  = rd_data_s;
  assign late_s  = now_r - head_s.due;
  assign pop_s   = en && !empty_s && !late_s[TS_W-1];
  assign space_s = !full_s || pop_s;

  assign rel_vel_s = atten_vel(rel_r.vel, decay, rel_r.on);

`ifdef ECHO_FEEDBACK_EN
  logic [RPT_W-1:0] rel_rpt_r;
  logic [TS_W-1:0]  rel_due_r;
  evt_t             skid_r;
  evt_t             rep_evt_s;
  logic             skid_v_r;
  logic             rep_need_s;
  logic             skid_wr_s;

  // Write-port arbitration: fresh captures win, the skid entry fills idle cycles.
  always_comb begin
    rep_evt_s.f     = rel_r;
    rep_evt_s.f.vel = rel_vel_s;
    rep_evt_s.rpt   = rel_rpt_r + RPT_W'(1);
    rep_evt_s.due   = rel_due_r + delay_ticks;
    rep_need_s = en && rel_v_r && (rel_rpt_r < RPT_W'(MAX_REPEATS)) &&
                 (!rel_r.on || (rel_vel_s > 7'd1));
    skid_wr_s  = en && skid_v_r && !change_s && space_s;
    push_s     = (change_s && space_s) || skid_wr_s;
    if (change_s) begin
      wr_evt_s = cap_evt_s;
    end else begin
      wr_evt_s = skid_r;
    end
    drop_s = (change_s && !space_s) || (rep_need_s && skid_v_r && !skid_wr_s);
  end

  // One-entry skid holding a repeat until the write port is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_v_r <= 1'b0;
      skid_r   <= '0;
    end else if (rep_need_s && (!skid_v_r || skid_wr_s)) begin
      skid_v_r <= 1'b1;
      skid_r   <= rep_evt_s;
    end else if (skid_wr_s) begin
      skid_v_r <= 1'b0;
    end
  end

  // Repeat bookkeeping travels alongside the released fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_rpt_r <= '0;
      rel_due_r <= '0;
    end else if (pop_s) begin
      rel_rpt_r <= head_s.rpt;
      rel_due_r <= head_s.due;
    end
  end
`else
  // Captures are the only writer.
  always_comb begin
    push_s   = change_s && space_s;
    wr_evt_s = cap_evt_s;
    drop_s   = change_s && !space_s;
  end
`endif

  echo_event_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wr_evt_s),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

  assign fill_level = count_s;

  // Release stage: the popped entry waits here one cycle before reaching the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_v_r <= 1'b0;
      rel_r   <= '0;
    end else if (en) begin
      rel_v_r <= pop_s;
      if (pop_s) begin
        rel_r <= head_s.f;
      end
    end
  end

  // Held echo outputs and the one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_valid <= 1'b0;
      echo_on    <= 1'b0;
      echo_note  <= '0;
      echo_vel   <= '0;
      echo_pb    <= '0;
      echo_cc1   <= '0;
    end else if (en) begin
      echo_valid <= rel_v_r;
      if (rel_v_r) begin
        echo_on   <= rel_r.on;
        echo_note <= rel_r.note;
        echo_vel  <= rel_vel_s;
        echo_pb   <= rel_r.pb;
        echo_cc1  <= rel_r.cc1;
      end
    end else begin
      echo_valid <= 1'b0;
    end
  end

  // Sticky record of any dropped event.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_delay_line.sv
// Directed self-checking bench for echo_delay_line (DEPTH=4, TS_W=8, TICK_DIV=1).
module tb_echo_delay_line;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       note_on = 1'b0;
  logic       note_repeat = 1'b0;
  logic [6:0] note_start = 7'd0;
  logic [6:0] vel_start = 7'd0;
  logic [8:0] pb_start = 9'd0;
  logic [1:0] cc1_start = 2'd0;
  logic [7:0] delay_ticks = 8'd100;
  logic [1:0] decay = 2'd0;
  logic       echo_valid;
  logic       echo_on;
  logic [6:0] echo_note;
  logic [6:0] echo_vel;
  logic [8:0] echo_pb;
  logic [1:0] echo_cc1;
  logic [2:0] fill_level;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;

  echo_delay_line #(
    .DEPTH(4), .TS_W(8), .TICK_DIV(1), .PB_W(9), .CC_W(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .note_on(note_on), .note_repeat(note_repeat),
    .note_start(note_start), .vel_start(vel_start), .pb_start(pb_start),
    .cc1_start(cc1_start), .delay_ticks(delay_ticks), .decay(decay),
    .echo_valid(echo_valid), .echo_on(echo_on), .echo_note(echo_note),
    .echo_vel(echo_vel), .echo_pb(echo_pb), .echo_cc1(echo_cc1),
    .fill_level(fill_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; cyc is the index of the next edge that will sample inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (echo_valid) pulses++;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    note_on = 1'b0; note_repeat = 1'b0; note_start = 7'd0; vel_start = 7'd0;
    pb_start = 9'd0; cc1_start = 2'd0; en = 1'b1;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    cyc = 0;
    pulses = 0;
  endtask

  // Returns the edge index at which echo_valid was seen, or -1 on timeout.
  task automatic wait_echo(input int maxn, output int e);
    e = -1;
    for (int i = 0; i < maxn; i++) begin
      step();
      if (echo_valid) begin
        e = cyc - 1;
        return;
      end
    end
  endtask

  int e;
  int cap;

  initial begin
    do_reset();
    chk_eq("rst_valid", echo_valid, 0);
    chk_eq("rst_on", echo_on, 0);
    chk_eq("rst_note", echo_note, 0);
    chk_eq("rst_vel", echo_vel, 0);
    chk_eq("rst_fill", fill_level, 0);
    chk_eq("rst_ovf", overflow, 0);

    // Note-on captured at edge 0, note-off at edge 20.
    delay_ticks = 8'd100; decay = 2'd0;
    note_on = 1'b1; note_start = 7'd60; vel_start = 7'd100;
    step_n(20);
    chk_eq("t1_fill", fill_level, 1);
    note_on = 1'b0;
    wait_echo(200, e);
    chk_eq("t1_edge", e, 101);
    chk_eq("t1_on", echo_on, 1);
    chk_eq("t1_note", echo_note, 60);
    chk_eq("t1_vel", echo_vel, 50);
    step();
    chk_eq("t1_pulse_len", echo_valid, 0);
    wait_echo(200, e);
    chk_eq("t2_edge", e, 121);
    chk_eq("t2_on", echo_on, 0);
    chk_eq("t2_note", echo_note, 60);
    chk_eq("t2_vel", echo_vel, 100);
    chk_eq("t2_fill", fill_level, 0);

    // Small velocity with heavy decay clamps to 1; pb/cc1 carried through.
    cap = cyc;
    decay = 2'd3; note_on = 1'b1; vel_start = 7'd3; pb_start = 9'd300; cc1_start = 2'd2;
    wait_echo(200, e);
    chk_eq("t2b_edge", e, cap + 101);
    chk_eq("t2b_vel", echo_vel, 1);
    chk_eq("t2b_pb", echo_pb, 300);
    chk_eq("t2b_cc1", echo_cc1, 2);

    // Timestamp wrap: capture at now=230, due=24.
    do_reset();
    delay_ticks = 8'd50; decay = 2'd1;
    step_n(230);
    note_on = 1'b1; note_start = 7'd70; vel_start = 7'd40;
    wait_echo(200, e);
    chk_eq("t3_edge", e, 281);
    chk_eq("t3_vel", echo_vel, 10);
    pulses = 0;
    step_n(300);
    chk_eq("t3_once", pulses, 0);

    // Overflow: 5 changes into a 4-deep FIFO.
    do_reset();
    delay_ticks = 8'd100; decay = 2'd0;
    note_on = 1'b1; vel_start = 7'd80;
    for (int k = 0; k < 5; k++) begin
      note_start = 7'(10 + k);
      step();
    end
    chk_eq("t4_fill", fill_level, 4);
    chk_eq("t4_ovf", overflow, 1);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (echo_valid) chk_eq("t4_note", echo_note, 10 + pulses - 1);
    end
    chk_eq("t4_count", pulses, 4);
    chk_eq("t4_fill_end", fill_level, 0);
    chk_eq("t4_ovf_sticky", overflow, 1);

    // Reset with 3 entries pending discards them.
    do_reset();
    note_on = 1'b1; vel_start = 7'd90;
    for (int k = 0; k < 3; k++) begin
      note_start = 7'(20 + k);
      step();
    end
    step_n(10);
    chk_eq("t5_fill_pre", fill_level, 3);
    do_reset();
    chk_eq("t5_fill", fill_level, 0);
    chk_eq("t5_ovf", overflow, 0);
    chk_eq("t5_note", echo_note, 0);
    step_n(200);
    chk_eq("t5_silent", pulses, 0);

    // en=0 freezes time: echo slips by the 30 disabled cycles.
    do_reset();
    delay_ticks = 8'd10; decay = 2'd0;
    note_on = 1'b1; note_start = 7'd5; vel_start = 7'd64;
    step_n(5);
    en = 1'b0;
    step_n(30);
    chk_eq("t6_frozen", pulses, 0);
    chk_eq("t6_fill", fill_level, 1);
    en = 1'b1;
    wait_echo(100, e);
    chk_eq("t6_edge", e, 41);
    chk_eq("t6_vel", echo_vel, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
